mac_operand_sequencer: RTL and testbench

Drives the int8/fp16 MAC from the command side. It accepts a dot-product command, streams operand pairs into the MAC with one pair per cycle, and issues the synchronous clear at the start of each command. After the final pair it waits out the MAC pipeline latency, then captures the accumulator and returns it on a result handshake. It sits between the operand buffer/DMA and the MAC instance.

---
 rtl/mac_operand_sequencer.sv | 123 ++++++++++++
 tb/tb_mac_operand_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_operand_sequencer.sv
// Command-side sequencer for the int8/fp16 MAC: clears the accumulator, streams
// one operand pair per cycle, waits out the MAC latency and returns the result.
module mac_operand_sequencer #(
  parameter int LEN_W   = 8,
  parameter int FP_LAT  = 3,
  parameter int INT_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_float,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [15:0]      op_a,
  input  logic [15:0]      op_b,
  output logic             mac_clear,
  output logic             mac_float_int,
  output logic [15:0]      mac_a,
  output logic [15:0]      mac_b,
  input  logic [15:0]      mac_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_data,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_RESULT
  } state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] cnt;
  logic             mode_r;
  logic             ready_en;
  logic [7:0]       dcnt;
  logic [7:0]       d_last;
  logic             cmd_fire;
  logic             op_fire;
  logic             res_fire;
  logic             drain_done;

  // Drain from FEED starts at dcnt=0 (the cycle the last pair sits on mac_a/b);
  // from CLEAR it starts at 1, so both wait D cycles after the last input.
  assign d_last     = mode_r ? 8'(FP_LAT + 1) : 8'(INT_LAT + 1);
  assign cmd_fire   = cmd_valid & cmd_ready;
  assign op_fire    = op_valid & op_ready;
  assign res_fire   = res_valid & res_ready;
  assign drain_done = (state == S_DRAIN) && (dcnt == d_last);

  // NOTE: reset is active-high on rst_n here, so the async sensitivity is posedge rst_n.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (cmd_fire) state_nxt = S_CLEAR;
      S_CLEAR:  state_nxt = (len_r != '0) ? S_FEED : S_DRAIN;
      S_FEED:   if (op_fire && (cnt + LEN_W'(1) == len_r)) state_nxt = S_DRAIN;
      S_DRAIN:  if (drain_done) state_nxt = S_RESULT;
      S_RESULT: if (res_fire) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    op_ready  = 1'b0;
    mac_clear = 1'b0;
    res_valid = 1'b0;
    busy      = (state != S_IDLE);
    unique case (state)
      S_IDLE:   cmd_ready = ready_en;
      S_CLEAR:  mac_clear = 1'b1;
      S_FEED:   op_ready  = (cnt < len_r);
      S_RESULT: res_valid = 1'b1;
      default:  ;
    endcase
  end

  assign mac_float_int = mode_r;

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      ready_en <= 1'b0;
      len_r    <= '0;
      cnt      <= '0;
      mode_r   <= 1'b0;
      dcnt     <= '0;
      mac_a    <= '0;
      mac_b    <= '0;
      res_data <= '0;
    end else begin
      ready_en <= 1'b1;
      if (cmd_fire) begin
        len_r  <= cmd_len;
        mode_r <= cmd_float;
        cnt    <= '0;
      end else if (op_fire) begin
        cnt <= cnt + LEN_W'(1);
      end
      // Gap cycles present zeros, which is a no-op accumulate in either mode.
      mac_a <= op_fire ? op_a : 16'h0000;
      mac_b <= op_fire ? op_b : 16'h0000;
      if (state == S_CLEAR)      dcnt <= 8'd1;
      else if (state == S_FEED)  dcnt <= 8'd0;
      else if (state == S_DRAIN) dcnt <= dcnt + 8'd1;
      if (drain_done) res_data <= mac_out;
    end
  end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Directed bench for mac_operand_sequencer with a behavioural int8/fp16 MAC model
// (accumulator plus latency pipeline) driving mac_out.
module tb_mac_operand_sequencer;

  localparam int LEN_W   = 8;
  localparam int FP_LAT  = 3;
  localparam int INT_LAT = 2;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_float;
  logic             op_valid;
  logic             op_ready;
  logic [15:0]      op_a;
  logic [15:0]      op_b;
  logic             mac_clear;
  logic             mac_float_int;
  logic [15:0]      mac_a;
  logic [15:0]      mac_b;
  logic [15:0]      mac_out;
  logic             res_valid;
  logic             res_ready;
  logic [15:0]      res_data;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;
  int clear_cnt = 0;
  int accept_cnt = 0;

  mac_operand_sequencer #(
    .LEN_W  (LEN_W),
    .FP_LAT (FP_LAT),
    .INT_LAT(INT_LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_len      (cmd_len),
    .cmd_float    (cmd_float),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_a         (op_a),
    .op_b         (op_b),
    .mac_clear    (mac_clear),
    .mac_float_int(mac_float_int),
    .mac_a        (mac_a),
    .mac_b        (mac_b),
    .mac_out      (mac_out),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural MAC model ----------------
  function automatic real h2r(input logic [15:0] h);
    real m;
    int  e;
    m = real'(h[9:0]) / 1024.0;
    e = int'(h[14:10]);
    if (e == 0) e = 1;
    else        m = m + 1.0;
    for (int i = 0; i < 15 - e; i++) m = m / 2.0;
    for (int i = 0; i < e - 15; i++) m = m * 2.0;
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2h(input real r_in);
    real  r;
    logic s;
    int   e;
    r = r_in;
    s = (r < 0.0);
    if (s) r = -r;
    if (r == 0.0) return 16'h0000;
    e = 15;
    while (r >= 2.0 && e < 31) begin r = r / 2.0; e++; end
    while (r < 1.0 && e > 1) begin r = r * 2.0; e--; end
    if (r < 1.0) return {s, 5'd0, 10'(int'(r * 1024.0))};
    return {s, 5'(e), 10'(int'((r - 1.0) * 1024.0))};
  endfunction

  int          acc_i = 0;
  real         acc_r = 0.0;
  logic [15:0] pipe [4];

  initial for (int i = 0; i < 4; i++) pipe[i] = 16'h0000;

  always @(posedge clk) begin
    int  nxt_i;
    real nxt_r;
    if (mac_clear) begin
      nxt_i = 0;
      nxt_r = 0.0;
    end else begin
      nxt_i = acc_i + int'($signed(mac_a[7:0])) * int'($signed(mac_b[7:0]));
      nxt_r = acc_r + h2r(mac_a) * h2r(mac_b);
    end
    acc_i   <= nxt_i;
    acc_r   <= nxt_r;
    pipe[0] <= mac_float_int ? r2h(nxt_r) : nxt_i[15:0];
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
    pipe[3] <= pipe[2];
  end

  assign mac_out = mac_float_int ? pipe[FP_LAT-1] : pipe[INT_LAT-1];

  always @(posedge clk) begin
    if (mac_clear) clear_cnt <= clear_cnt + 1;
    if (op_valid && op_ready) accept_cnt <= accept_cnt + 1;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a command from IDLE; returns positioned in the CLEAR cycle.
  task automatic send_cmd(input logic [LEN_W-1:0] len, input logic fl);
    cmd_valid = 1'b1;
    cmd_len   = len;
    cmd_float = fl;
    step();
    cmd_valid = 1'b0;
  endtask

  // Present a pair for acceptance and confirm it lands on mac_a/mac_b next cycle.
  task automatic feed_pair(input string tag, input logic [15:0] a, input logic [15:0] b);
    op_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    step();
    check({tag, "_mac_ab"}, {mac_a, mac_b}, {a, b});
  endtask

  // Step until res_valid; all drain cycles must keep the MAC inputs quiet.
  task automatic wait_res(input string tag, input int exp_steps, input logic fl);
    int   n;
    logic bad;
    n   = 0;
    bad = 1'b0;
    while (n < 50) begin
      step();
      n++;
      if (mac_a != 16'h0 || mac_b != 16'h0 || op_ready || mac_clear || cmd_ready ||
          mac_float_int != fl || !busy) bad = 1'b1;
      if (res_valid) break;
    end
    check({tag, "_drain_steps"}, n, exp_steps);
    check({tag, "_drain_quiet"}, bad, 1'b0);
  endtask

  task automatic finish_res(input string tag);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check({tag, "_idle"}, {res_valid, busy, cmd_ready}, 3'b001);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int c0;
    int a0;
    bit pat [7];
    logic [15:0] pa [4];
    logic [15:0] pb [4];
    int k;
    logic [15:0] held;

    rst_n     = 1'b1;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    cmd_float = 1'b0;
    op_valid  = 1'b0;
    op_a      = 16'h0;
    op_b      = 16'h0;
    res_ready = 1'b0;

    #2;
    check("reset_outputs",
          {cmd_ready, op_ready, mac_clear, mac_float_int, res_valid, busy, mac_a, mac_b, res_data},
          '0);
    step();
    step();
    rst_n = 1'b0;
    check("cmd_ready_low_at_release", cmd_ready, 1'b0);
    step();
    check("idle_after_release", {cmd_ready, busy}, 2'b10);

    // Test 1: int8, 3 back-to-back pairs -> 2+12+30 = 44
    c0 = clear_cnt;
    send_cmd(8'd3, 1'b0);
    check("t1_clear", {mac_clear, busy, cmd_ready, op_ready, mac_a, mac_b}, {4'b1100, 32'h0});
    op_valid = 1'b1;
    op_a = 16'd1;
    op_b = 16'd2;
    step();
    check("t1_feed_entry", {op_ready, mac_clear, mac_a}, {2'b10, 16'h0});
    step();
    check("t1_pair0", {mac_a, mac_b}, {16'd1, 16'd2});
    feed_pair("t1_p1", 16'd3, 16'd4);
    feed_pair("t1_p2", 16'd5, 16'd6);
    op_valid = 1'b0;
    check("t1_op_ready_drop", op_ready, 1'b0);
    wait_res("t1", INT_LAT + 2, 1'b0);
    check("t1_clear_pulses", clear_cnt - c0, 1);
    check("t1_res", {res_valid, res_data}, {1'b1, 16'h002C});
    finish_res("t1");

    // Test 2: fp16, 1.0*2.0 + 0.5*4.0 = 4.0, with a 10-cycle result stall
    send_cmd(8'd2, 1'b1);
    check("t2_clear_float", {mac_clear, mac_float_int}, 2'b11);
    op_valid = 1'b1;
    op_a = 16'h3C00;
    op_b = 16'h4000;
    step();
    step();
    check("t2_pair0", {mac_a, mac_b}, {16'h3C00, 16'h4000});
    feed_pair("t2_p1", 16'h3800, 16'h4400);
    op_valid = 1'b0;
    wait_res("t2", FP_LAT + 2, 1'b1);
    check("t2_res", {res_valid, res_data}, {1'b1, 16'h4400});
    held = res_data;
    a0 = 0;
    cmd_valid = 1'b1;
    cmd_len   = 8'd5;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!res_valid || res_data !== held || cmd_ready || mac_clear) a0++;
    end
    cmd_valid = 1'b0;
    check("t2_stall_stable", a0, 0);
    check("t2_stall_res", {res_valid, res_data}, {1'b1, 16'h4400});
    finish_res("t2");
    check("t2_float_holds_idle", mac_float_int, 1'b1);

    // Test 3: int8 len 4 with gapped valid -> 6+20+7+36 = 69
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    pa  = '{16'd2, 16'd4, 16'd1, 16'd6};
    pb  = '{16'd3, 16'd5, 16'd7, 16'd6};
    a0 = accept_cnt;
    send_cmd(8'd4, 1'b0);
    step();
    k = 0;
    for (int i = 0; i < 7; i++) begin
      op_valid = pat[i];
      op_a = pa[k];
      op_b = pb[k];
      step();
      if (pat[i]) begin
        check("t3_pair", {mac_a, mac_b}, {pa[k], pb[k]});
        k++;
      end else begin
        check("t3_gap_zero", {mac_a, mac_b}, 32'h0);
      end
    end
    op_valid = 1'b1;
    op_a = 16'h0077;
    op_b = 16'h0077;
    check("t3_op_ready_drop", op_ready, 1'b0);
    wait_res("t3", INT_LAT + 2, 1'b0);
    op_valid = 1'b0;
    check("t3_accepts", accept_cnt - a0, 4);
    check("t3_res", res_data, 16'h0045);
    finish_res("t3");

    // Test 4: zero-length command
    c0 = clear_cnt;
    a0 = accept_cnt;
    send_cmd(8'd0, 1'b0);
    check("t4_clear", {mac_clear, op_ready}, 2'b10);
    wait_res("t4", INT_LAT + 2, 1'b0);
    check("t4_counts", {clear_cnt - c0, accept_cnt - a0}, {32'd1, 32'd0});
    check("t4_res", {res_valid, res_data}, {1'b1, 16'h0000});
    finish_res("t4");

    // Test 5: reset mid-FEED after 2 of 5 pairs, then a fresh command
    send_cmd(8'd5, 1'b1);
    op_valid = 1'b1;
    op_a = 16'h3C00;
    op_b = 16'h3C00;
    step();
    step();
    feed_pair("t5_p1", 16'h4000, 16'h4000);
    #2;
    rst_n = 1'b1;
    #1;
    check("t5_reset_outputs",
          {cmd_ready, op_ready, mac_clear, mac_float_int, res_valid, busy, mac_a, mac_b, res_data},
          '0);
    op_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    check("t5_idle_after_reset", {cmd_ready, busy, op_ready}, 3'b100);
    send_cmd(8'd2, 1'b0);
    op_valid = 1'b1;
    op_a = 16'd7;
    op_b = 16'd8;
    step();
    step();
    check("t5_pair0", {mac_a, mac_b}, {16'd7, 16'd8});
    feed_pair("t5_p1b", 16'd9, 16'd1);
    op_valid = 1'b0;
    wait_res("t5", INT_LAT + 2, 1'b0);
    check("t5_res", res_data, 16'h0041);
    finish_res("t5");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
